// File: rtl/ecc_secded_dec_pipe.sv
// Two-stage pipelined SEC-DED decoder for 8/16/32-bit extended-Hamming
// codewords. The mode is chosen per word. Stage 1 registers the codeword,
// the mode and the syndrome. Stage 2 registers the corrected info bits and
// the error classification. Saturating counters track corrected and
// uncorrectable results.
module ecc_secded_dec_pipe #(
  parameter int unsigned MAX_CODEWORD_WIDTH = 32,
  parameter int unsigned AMBA_WORD          = 32,
  parameter int unsigned CNT_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
  input  logic [AMBA_WORD-1:0]          work_mod,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
  output logic [1:0]                    num_of_errors,
  input  logic                          cnt_clr,
  output logic [CNT_WIDTH-1:0]          cnt_corrected,
  output logic [CNT_WIDTH-1:0]          cnt_uncorrectable
);

  localparam int unsigned MW = MAX_CODEWORD_WIDTH;

  typedef enum logic [1:0] {
    MODE_8   = 2'd0,
    MODE_16  = 2'd1,
    MODE_32  = 2'd2,
    MODE_BAD = 2'd3
  } mode_t;

  // Low P-1 bits of the H column for codeword bit b. The column MSB is
  // always 1, so it reduces to the overall parity of the word. Info bits
  // take the weight>=2 values in ascending order, parity bits take
  // one-hot values, and the overall parity bit takes zero.
  function automatic logic [4:0] h_col(input int unsigned k, input int unsigned pm1,
                                       input int unsigned b);
    logic [4:0]  c;
    int unsigned idx;
    c   = '0;
    idx = 0;
    if (b < k) begin
      for (int unsigned v = 3; v < 32; v++) begin
        if (v < (32'd1 << pm1) && $countones(v[4:0]) >= 2) begin
          if (idx == b) c = v[4:0];
          idx++;
        end
      end
    end else if (b < k + pm1) begin
      c = 5'(32'd1 << (b - k));
    end
    return c;
  endfunction

  // The syndrome is returned as {overall parity, low column bits}.
  // Bits at or above N are ignored.
  function automatic logic [5:0] calc_syn(input logic [31:0] w, input int unsigned k,
                                          input int unsigned pm1);
    logic [4:0] lo;
    logic       par;
    lo  = '0;
    par = 1'b0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b <= k + pm1 && w[b[4:0]]) begin
        lo  = lo ^ h_col(k, pm1, b);
        par = ~par;
      end
    end
    return {par, lo};
  endfunction

  // Returns {code, info bits}. An odd syndrome always matches exactly one
  // column, including the overall-parity column, which has a zero low part.
  function automatic logic [33:0] decode(input logic [31:0] w, input logic [5:0] syn,
                                         input int unsigned k, input int unsigned pm1);
    logic [31:0] kmask;
    logic [31:0] r;
    kmask = (32'd1 << k) - 32'd1;
    r     = w;
    if (syn[5]) begin
      for (int unsigned b = 0; b < 32; b++) begin
        if (b <= k + pm1 && h_col(k, pm1, b) == syn[4:0]) r[b[4:0]] = ~r[b[4:0]];
      end
    end
    if (syn == '0) return {2'd0, w & kmask};
    if (syn[5])    return {2'd1, r & kmask};
    return {2'd2, w & kmask};
  endfunction

  logic [31:0]   in_word;
  mode_t         in_mode;
  logic [5:0]    in_syn;

  logic          s1_valid;
  logic [MW-1:0] s1_word;
  mode_t         s1_mode;
  logic [5:0]    s1_syn;

  logic          s2_load;
  logic          s2_take;
  logic [31:0]   s2_data;
  logic [1:0]    s2_code;

  assign s2_load  = !out_valid | out_ready;
  assign in_ready = !s1_valid | s2_load;
  assign s2_take  = s2_load & s1_valid;

  // Decode the mode and compute the syndrome of the incoming word.
  always_comb begin
    in_word = 32'(data_in);
    in_mode = MODE_BAD;
    if (work_mod == AMBA_WORD'(0))                 in_mode = MODE_8;
    else if (work_mod == AMBA_WORD'(1) && MW >= 16) in_mode = MODE_16;
    else if (work_mod == AMBA_WORD'(2) && MW >= 32) in_mode = MODE_32;
    case (in_mode)
      MODE_8:  in_syn = calc_syn(in_word, 4, 3);
      MODE_16: in_syn = calc_syn(in_word, 11, 4);
      MODE_32: in_syn = calc_syn(in_word, 26, 5);
      default: in_syn = '0;
    endcase
  end

  // Stage 1: capture the word, its mode and its syndrome whenever the slot frees up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_mode  <= MODE_8;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= data_in;
        s1_mode <= in_mode;
        s1_syn  <= in_syn;
      end
    end
  end

  // Classify the stage-1 word and correct it. Illegal modes pass the raw word through.
  always_comb begin
    s2_code = 2'd3;
    s2_data = 32'(s1_word);
    case (s1_mode)
      MODE_8:  {s2_code, s2_data} = decode(32'(s1_word), s1_syn, 4, 3);
      MODE_16: {s2_code, s2_data} = decode(32'(s1_word), s1_syn, 11, 4);
      MODE_32: {s2_code, s2_data} = decode(32'(s1_word), s1_syn, 26, 5);
      default: ;
    endcase
  end

  // Stage 2: the output register. It holds while stalled and fills whenever it is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      data_out      <= '0;
      num_of_errors <= 2'd0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out      <= s2_data[MW-1:0];
        num_of_errors <= s2_code;
      end
    end
  end

  // Saturating statistics, counted as results enter stage 2. A clear wins over an increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clr) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (s2_take) begin
      if (s2_code == 2'd1 && cnt_corrected != '1)
        cnt_corrected <= cnt_corrected + CNT_WIDTH'(1);
      if (s2_code[1] && cnt_uncorrectable != '1)
        cnt_uncorrectable <= cnt_uncorrectable + CNT_WIDTH'(1);
    end
  end

endmodule
